cpu_sequencer: RTL

- Multi-cycle control FSM for the 8-bit accumulator CPU.
- Sits directly upstream of the ALU and datapath. It steps each instruction through eight phases and decodes the 3-bit instruction opcode into the datapath strobes (memory read/write, IR/AC/PC loads, PC increment, address mux select).
- Consumes the ALU's a_is_zero flag for skip-if-zero.
- Adds a memory-ready stall, a latched halt with resume, and a retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit accumulator CPU.
//
// It walks each instruction through eight phases (INST_ADDR .. STORE) and
// decodes the 3-bit opcode held in the IR into the datapath strobes. It adds
// a memory-ready stall in the memory phases, a latched halt with resume, and
// a retired-instruction counter.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode[2:0]         opcode from the IR (held stable by the IR)
//   zero                ALU a_is_zero flag, used by SKZ in ALU_OP only
//   mem_ready           memory completes the current read/write this cycle
//   resume              leave HALTED (ignored in every other state)
//   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e
//                       datapath strobes
//   halt                CPU halted
//   phase[2:0]          current phase (HALTED reads 4)
//   instr_count         instructions retired since reset, wraps
//
// The strobes decode the state register combinationally, so an asynchronous
// reset drives them to their reset values without waiting for a clock edge.
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_aluop_s;
  logic             is_hlt_s;
  logic             is_skz_s;
  logic             is_sto_s;
  logic             is_jmp_s;
  logic             stall_s;

  // Opcode class decodes shared by transitions and strobes.
  always_comb begin
    is_aluop_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
    is_hlt_s   = (opcode == OP_HLT);
    is_skz_s   = (opcode == OP_SKZ);
    is_sto_s   = (opcode == OP_STO);
    is_jmp_s   = (opcode == OP_JMP);
  end

  // Memory-ready stall: only phases that actually wait on memory may hold.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      S_INST_FETCH: stall_s = !mem_ready;
      S_OP_FETCH:   stall_s = is_aluop_s && !mem_ready;
      S_STORE:      stall_s = is_sto_s && !mem_ready;
      default:      stall_s = 1'b0;
    endcase
  end

  // Next-state selection; a stalled phase simply repeats itself.
  always_comb begin
    state_d = state_q;
    if (stall_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_INST_ADDR:  state_d = S_INST_FETCH;
        S_INST_FETCH: state_d = S_INST_LOAD;
        S_INST_LOAD:  state_d = S_IDLE;
        S_IDLE:       state_d = S_OP_ADDR;
        S_OP_ADDR:    state_d = is_hlt_s ? S_HALTED : S_OP_FETCH;
        S_OP_FETCH:   state_d = S_ALU_OP;
        S_ALU_OP:     state_d = S_STORE;
        S_STORE:      state_d = S_INST_ADDR;
        S_HALTED:     state_d = resume ? S_INST_ADDR : S_HALTED;
        default:      state_d = S_INST_ADDR;
      endcase
    end
  end

  // Retire count: bumps on the non-stalled edge leaving STORE, wraps freely.
  // HLT never reaches STORE, so it is never counted.
  always_comb begin
    if ((state_q == S_STORE) && !stall_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State and retire-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INST_ADDR;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Strobe decode from the current state and the IR opcode.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = 3'd0;
    case (state_q)
      S_INST_ADDR: begin
        sel   = 1'b1;
        phase = 3'd0;
      end
      S_INST_FETCH: begin
        sel   = 1'b1;
        rd    = 1'b1;
        phase = 3'd1;
      end
      S_INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
        phase = 3'd2;
      end
      S_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
        phase = 3'd3;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt_s;
        phase  = 3'd4;
      end
      S_OP_FETCH: begin
        rd    = is_aluop_s;
        phase = 3'd5;
      end
      S_ALU_OP: begin
        rd     = is_aluop_s;
        inc_pc = is_skz_s && zero;
        ld_pc  = is_jmp_s;
        data_e = is_sto_s;
        phase  = 3'd6;
      end
      S_STORE: begin
        rd     = is_aluop_s;
        ld_ac  = is_aluop_s;
        ld_pc  = is_jmp_s;
        wr     = is_sto_s;
        data_e = is_sto_s;
        phase  = 3'd7;
      end
      S_HALTED: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: begin
        sel   = 1'b1;
        phase = 3'd0;
      end
    endcase
  end

  assign instr_count = count_q;

endmodule
